// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported PDP-8 memory between the instruction-fetch read
// port and the execution unit's read and write ports. Every transaction is
// closed with a one-cycle acknowledge to whichever requester owned it.
//
// Arbitration is fixed priority (exec write > exec read > fetch) with a
// starvation guard: once STARVE_LIMIT exec grants have been made while a
// fetch was waiting, the fetch is granted next regardless of exec traffic.
//
// Ports
//   clk, reset_n                  clock (rising edge), async active-low reset
//   ifu_rd_req/addr               fetch read request (level) and address
//   ifu_rd_data/ack               registered fetch data and completion pulse
//   exec_rd_req/addr              exec read request (level) and address
//   exec_rd_data                  registered exec read data
//   exec_wr_req/addr/data         exec write request (level), address, data
//   exec_ack                      completion pulse for the granted exec op
//   mem_req/we/addr/wdata         single-port memory strobe and command
//   mem_rdata                     memory read data, valid one cycle after
//                                 a read strobe
//   arb_busy                      high whenever a transaction is in flight
//
// Every output is either a register or a decode of the state register and
// the latched owner, so there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_ack,

    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,

    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  exec_ack,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  arb_busy
);

    // The starvation counter is 4 bits wide, enough for limits up to 15.
    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_ownerIfu;
    logic [DATA_WIDTH-1:0] r_ifuData;
    logic [DATA_WIDTH-1:0] r_execData;
    logic [3:0]            r_starveCnt;

    logic                  w_starved;
    logic                  w_grantWr;
    logic                  w_grantExecRd;
    logic                  w_grantIfu;
    logic                  w_grantExec;
    logic                  w_grantAny;

    // Grant decode. These are only acted on in IDLE. A starved fetch
    // pre-empts both exec ports; otherwise the write beats the read and
    // the fetch only wins when the exec unit is silent.
    assign w_starved     = ifu_rd_req && (r_starveCnt == C_STARVE_LIMIT);
    assign w_grantIfu    = ifu_rd_req && (w_starved || (!exec_wr_req && !exec_rd_req));
    assign w_grantWr     = exec_wr_req && !w_starved;
    assign w_grantExecRd = exec_rd_req && !exec_wr_req && !w_starved;
    assign w_grantExec   = w_grantWr || w_grantExecRd;
    assign w_grantAny    = w_grantExec || w_grantIfu;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_grantWr) begin
                    w_nextState = WR_ISSUE;
                end else if (w_grantAny) begin
                    w_nextState = RD_ISSUE;
                end else begin
                    w_nextState = IDLE;
                end
            end
            RD_ISSUE: w_nextState = RD_WAIT;
            RD_WAIT:  w_nextState = RESP;
            WR_ISSUE: w_nextState = RESP;
            RESP:     w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode: strobes and acks come straight from the state, the
    // ack is steered by the owner latched at grant time.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ifu_rd_ack = 1'b0;
        exec_ack   = 1'b0;
        arb_busy   = 1'b1;
        case (r_state)
            IDLE: begin
                arb_busy = 1'b0;
            end
            RD_ISSUE: begin
                mem_req = 1'b1;
            end
            WR_ISSUE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            RESP: begin
                ifu_rd_ack = r_ownerIfu;
                exec_ack   = !r_ownerIfu;
            end
            default: begin
                arb_busy = 1'b1;
            end
        endcase
    end

    // The memory address and write data come straight from the grant latch,
    // which only changes on a grant, so they hold between accesses.
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign ifu_rd_data  = r_ifuData;
    assign exec_rd_data = r_execData;

    // -----------------------------------------------------------------------
    // Grant latch: address, owner, and (for writes only) the write data.
    // Read grants leave the write data alone so mem_wdata keeps the value
    // of the last write.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ownerIfu <= 1'b0;
        end else if (r_state == IDLE && w_grantAny) begin
            r_ownerIfu <= w_grantIfu;
            if (w_grantIfu) begin
                r_addr <= ifu_rd_addr;
            end else if (w_grantWr) begin
                r_addr  <= exec_wr_addr;
                r_wdata <= exec_wr_data;
            end else begin
                r_addr <= exec_rd_addr;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read data capture. The memory presents data during RD_WAIT; it is
    // registered into the owner's holding register, which keeps the value
    // until that requester's next completed read.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ifuData  <= '0;
            r_execData <= '0;
        end else if (r_state == RD_WAIT) begin
            if (r_ownerIfu) begin
                r_ifuData <= mem_rdata;
            end else begin
                r_execData <= mem_rdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Starvation counter. Counts exec grants made while a fetch is waiting,
    // saturating at the limit. Any fetch grant, or any idle cycle without a
    // pending fetch, returns it to zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starveCnt <= '0;
        end else if (r_state == IDLE) begin
            if (!ifu_rd_req || w_grantIfu) begin
                r_starveCnt <= '0;
            end else if (w_grantExec && (r_starveCnt != C_STARVE_LIMIT)) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the instruction-fetch read port and the execution unit's read and write ports onto one single-port PDP-8 memory. It sits between `instr_decode`/`instr_exec` and a single-ported `memory_pdp` variant. Each transaction completes with an explicit one-cycle acknowledge. Fixed priority is used, with a starvation guard so fetches cannot be locked out by a long run of execution-unit traffic.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- ADDR_WIDTH, 12, word address width.
- DATA_WIDTH, 12, word width.
- STARVE_LIMIT, 4, consecutive exec grants tolerated while a fetch waits; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ifu_rd_req  in  1  fetch read request, level, held until ack.
- ifu_rd_addr  in  ADDR_WIDTH  fetch address, stable while req high.
- ifu_rd_data  out  DATA_WIDTH  registered fetch data, valid when ifu_rd_ack=1.
- ifu_rd_ack  out  1  one-cycle fetch completion pulse.
- exec_rd_req  in  1  exec read request, level.
- exec_rd_addr  in  ADDR_WIDTH  exec read address.
- exec_rd_data  out  DATA_WIDTH  registered exec read data, valid when exec_ack=1.
- exec_wr_req  in  1  exec write request, level.
- exec_wr_addr  in  ADDR_WIDTH  exec write address.
- exec_wr_data  in  DATA_WIDTH  exec write data.
- exec_ack  out  1  one-cycle completion pulse for the granted exec read or write.
- mem_req  out  1  memory strobe, high for exactly one cycle per access.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_req with mem_we=0.
- arb_busy  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE samples requests. The grant is latched with its address, write data and owner.
  - Winner is a write: go to WR_ISSUE.
  - Winner is a read: go to RD_ISSUE.
  - No request: stay in IDLE.
- Priority: exec_wr > exec_rd > ifu_rd.
- Starvation override: if ifu_rd_req=1 and starve_cnt == STARVE_LIMIT, ifu wins.
- starve_cnt behaviour:
  - Increments, saturating at STARVE_LIMIT, on each exec grant made while ifu_rd_req=1.
  - Clears on an ifu grant.
  - Clears on any IDLE cycle with ifu_rd_req=0.
- RD_ISSUE: mem_req=1, mem_we=0, mem_addr=latched address. Next state is RD_WAIT.
- RD_WAIT: mem_rdata is captured at the clock edge into the owner's data register. Next state is RESP.
- WR_ISSUE: mem_req=1, mem_we=1, mem_addr and mem_wdata come from the latch. Next state is RESP.
- RESP: the owner's ack=1 for one cycle. Next state is IDLE.
- Requester obligation: drop req in the cycle after ack. The arbiter never samples requests during RESP.
- Simultaneous exec_wr_req and exec_rd_req: the write is served first and acked, then the read is served. A read to the same address returns the new data.
- ifu_rd_data and exec_rd_data hold their last captured value until the next completed read for that requester.
- mem_addr and mem_wdata hold their last value outside the ISSUE states. mem_we=0 whenever mem_req=0.

## Timing
- Reset values, asserted immediately on reset_n low:
  - state=IDLE, starve_cnt=0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, ifu_rd_data, ifu_rd_ack, exec_rd_data, exec_ack, arb_busy.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Read latency: request seen in IDLE at cycle N gives mem_req at N+1, mem_rdata at N+2, and ack with data at N+3. Occupancy is 4 cycles including the IDLE cycle.
- Write latency: request at N gives mem_req/mem_we at N+1 and exec_ack at N+2. Occupancy is 3 cycles.
- Back-to-back: a new request may be granted in the IDLE cycle immediately following RESP.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. A write already strobed at mem_req is not undone. After reset release, pending level requests are re-arbitrated from IDLE.
- Address changes on a held req are ignored after the grant; the latched address is used.

## Test plan
- Single fetch: ifu_rd_req at addr 0o200 with memory holding 0o7402 -> mem_req at +1, ifu_rd_ack=1 and ifu_rd_data=0o7402 at +3; arb_busy high from +1 through +3.
- Exec write then read, same cycle: wr 0o123 to 0o050 plus rd 0o050 -> mem_we strobe first, exec_ack at +2; read strobe next; second exec_ack with exec_rd_data=0o123.
- Priority: ifu_rd and exec_rd asserted together, STARVE_LIMIT=4 -> exec served first and ifu served next, since the count is only 1.
- Starvation: exec_rd held continuously with ifu_rd pending -> exactly 4 exec acks, then ifu_rd_ack, then exec resumes; starve_cnt returns to 0.
- Reset mid-read: reset_n low during RD_WAIT -> no ack; all outputs 0 while reset is low; after release a still-held ifu_rd_req completes in 4 cycles.
- Idle hold: no requests for 20 cycles -> mem_req=0 throughout; data outputs keep their prior values.
